// File: rtl/fish_bite_timer_pkg.sv
// Shared game package: FSM state encodings and time-base constants.
package fish_bite_timer_pkg;

    // Round FSM states; encodings are fixed so debug probes stay stable.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StBite = 2'd2,
        StDone = 2'd3
    } state_e;

    // Default time base: one Tick per millisecond from a 50 MHz system clock.
    localparam int unsigned DefaultClkHz   = 50_000_000;
    localparam int unsigned DefaultTickHz  = 1_000;
    localparam int unsigned DefaultTickDiv = DefaultClkHz / DefaultTickHz;

    // Start is only honoured between rounds.
    function automatic logic is_armable(input state_e s);
        return (s == StIdle) || (s == StDone);
    endfunction

endpackage

// File: rtl/fish_bite_timer_rise_detect.sv
// Rising-edge detector for the debounced reel button.
module rise_detect (
    input  logic CLK,
    input  logic RST,
    input  logic In,
    output logic Pulse
);

    logic prev_q;

    // History resets high so a button held through reset is not an edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= In;
        end
    end

    assign Pulse = In & ~prev_q;

endmodule

// File: rtl/fish_bite_timer.sv
// Fishing mini-game round timer: random delay, bite window, result flags.
module fish_bite_timer
    import fish_bite_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Reel,
    input  logic             Tick,
    input  logic [WIDTH-1:0] RandIn,
    input  logic [WIDTH-1:0] Window,
    output logic             RandRun,
    output logic             Bite,
    output logic             Caught,
    output logic             Missed,
    output logic             Early,
    output logic             Busy,
    output logic [WIDTH-1:0] Remain
);

    state_e           state_q;
    logic [WIDTH-1:0] delay_cnt_q;
    logic [WIDTH-1:0] win_cnt_q;
    logic             reel_edge;
    logic [WIDTH-1:0] delay_load;
    logic [WIDTH-1:0] win_load;

    rise_detect u_reel_edge (
        .CLK   (CLK),
        .RST   (RST),
        .In    (Reel),
        .Pulse (reel_edge)
    );

    // A zero length would never expire, so it is treated as one Tick.
    assign delay_load = (RandIn == '0) ? WIDTH'(1) : RandIn;
    assign win_load   = (Window == '0) ? WIDTH'(1) : Window;

    // Round FSM with all outputs registered alongside the state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            delay_cnt_q <= '0;
            win_cnt_q   <= '0;
            RandRun     <= 1'b0;
            Bite        <= 1'b0;
            Caught      <= 1'b0;
            Missed      <= 1'b0;
            Early       <= 1'b0;
            Busy        <= 1'b0;
            Remain      <= '0;
        end else begin
            RandRun <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (is_armable(state_q) && Start) begin
                        delay_cnt_q <= delay_load;
                        Remain      <= delay_load;
                        Caught      <= 1'b0;
                        Missed      <= 1'b0;
                        Early       <= 1'b0;
                        RandRun     <= 1'b1;
                        Busy        <= 1'b1;
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    // Reeling before the bite beats a same-cycle Tick.
                    if (reel_edge) begin
                        Early       <= 1'b1;
                        Busy        <= 1'b0;
                        Remain      <= '0;
                        delay_cnt_q <= '0;
                        state_q     <= StDone;
                    end else if (Tick) begin
                        if (delay_cnt_q <= WIDTH'(1)) begin
                            delay_cnt_q <= '0;
                            win_cnt_q   <= win_load;
                            Remain      <= win_load;
                            Bite        <= 1'b1;
                            state_q     <= StBite;
                        end else begin
                            delay_cnt_q <= delay_cnt_q - WIDTH'(1);
                            Remain      <= delay_cnt_q - WIDTH'(1);
                        end
                    end
                end
                StBite: begin
                    // A catch on the expiring Tick still counts as a catch.
                    if (reel_edge) begin
                        Caught    <= 1'b1;
                        Bite      <= 1'b0;
                        Busy      <= 1'b0;
                        Remain    <= '0;
                        win_cnt_q <= '0;
                        state_q   <= StDone;
                    end else if (Tick) begin
                        if (win_cnt_q <= WIDTH'(1)) begin
                            Missed    <= 1'b1;
                            Bite      <= 1'b0;
                            Busy      <= 1'b0;
                            Remain    <= '0;
                            win_cnt_q <= '0;
                            state_q   <= StDone;
                        end else begin
                            win_cnt_q <= win_cnt_q - WIDTH'(1);
                            Remain    <= win_cnt_q - WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fish_bite_timer.sv
// Self-checking bench for fish_bite_timer using an event-time reference model.
module tb_fish_bite_timer;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RST;
    logic         Start;
    logic         Reel;
    logic         Tick;
    logic [W-1:0] RandIn;
    logic [W-1:0] Window;
    logic         RandRun;
    logic         Bite;
    logic         Caught;
    logic         Missed;
    logic         Early;
    logic         Busy;
    logic [W-1:0] Remain;

    int n_cmp  = 0;
    int n_fail = 0;

    fish_bite_timer #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Start   (Start),
        .Reel    (Reel),
        .Tick    (Tick),
        .RandIn  (RandIn),
        .Window  (Window),
        .RandRun (RandRun),
        .Bite    (Bite),
        .Caught  (Caught),
        .Missed  (Missed),
        .Early   (Early),
        .Busy    (Busy),
        .Remain  (Remain)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic rr, input logic bt, input logic c,
                              input logic m, input logic e, input logic by,
                              input logic [W-1:0] rem);
        check({tag, " RandRun"}, W'(RandRun), W'(rr));
        check({tag, " Bite"},    W'(Bite),    W'(bt));
        check({tag, " Caught"},  W'(Caught),  W'(c));
        check({tag, " Missed"},  W'(Missed),  W'(m));
        check({tag, " Early"},   W'(Early),   W'(e));
        check({tag, " Busy"},    W'(Busy),    W'(by));
        check({tag, " Remain"},  Remain,      rem);
    endtask

    // One round. Cycle k=0 is the edge that samples Start. Ticks occur where
    // (k+ph)%p==0. kr: Reel edge cycle (-1 none, -2 random). ks: extra Start
    // pulse cycle during the round (-1 none). Outcome is derived from the
    // times of the d-th and (d+w)-th Ticks and the Reel edge time.
    task automatic run_round(input string name, input int d_in, input int w_in, input int p,
                             input int ph, input int kr_in, input int ks);
        int tk[$];
        int d, w, kb, ke, kend, outcome, kr, cnt;
        logic [W-1:0] rem;
        for (int k = 1; k < 400; k++) if ((k + ph) % p == 0) tk.push_back(k);
        d  = (d_in == 0) ? 1 : d_in;
        w  = (w_in == 0) ? 1 : w_in;
        kb = tk[d-1];
        ke = tk[d-1+w];
        kr = (kr_in == -2) ? int'($urandom_range(1, ke + 2)) : kr_in;
        // outcome: 0 missed, 1 caught, 2 early
        if (kr >= 1 && kr <= kb) begin
            outcome = 2; kend = kr;
        end else if (kr >= 1 && kr <= ke) begin
            outcome = 1; kend = kr;
        end else begin
            outcome = 0; kend = ke;
        end
        repeat (2) begin
            @(negedge CLK);
            Start  = 1'b0;
            Reel   = 1'b0;
            Tick   = 1'($urandom_range(0, 1));
            RandIn = W'($urandom);
            Window = W'($urandom);
        end
        for (int k = 0; k <= kend + 2; k++) begin
            @(negedge CLK);
            Start  = (k == 0) || (k == ks && k < kend);
            Tick   = ((k + ph) % p == 0);
            Reel   = (kr >= 1 && k >= kr);
            RandIn = (k == 0)  ? W'(d_in) : W'($urandom);
            Window = (k == kb) ? W'(w_in) : W'($urandom);
            @(posedge CLK);
            #1;
            cnt = 0;
            if (k >= kend) begin
                rem = '0;
            end else if (k < kb) begin
                foreach (tk[i]) if (tk[i] <= k) cnt++;
                rem = W'(d - cnt);
            end else begin
                foreach (tk[i]) if (tk[i] > kb && tk[i] <= k) cnt++;
                rem = W'(w - cnt);
            end
            check_outs($sformatf("%s k=%0d", name, k), (k == 0),
                       (outcome != 2) && (k >= kb) && (k < kend),
                       (outcome == 1) && (k >= kend), (outcome == 0) && (k >= kend),
                       (outcome == 2) && (k >= kend), (k < kend), rem);
        end
    endtask

    initial begin
        RST = 1'b1; Start = 1'b1; Reel = 1'b0; Tick = 1'b1;
        RandIn = W'(7); Window = W'(7);
        repeat (3) @(posedge CLK);
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge CLK);
        RST = 1'b0; Start = 1'b0; Tick = 1'b0;

        // Directed scenarios, Tick every 4 cycles (ticks at k=4,8,12,...).
        run_round("miss",      3, 2, 4, 0, -1, -1);
        run_round("early",     5, 3, 4, 0,  9, -1);
        run_round("catch",     2, 4, 4, 0,  9, -1);
        run_round("catch_exp", 2, 3, 4, 0, 20, -1);
        run_round("zero_len",  0, 0, 4, 0, -1,  2);
        run_round("reel_term", 2, 2, 4, 0,  8,  5);

        // Randomised rounds.
        for (int r = 0; r < 30; r++) begin
            int p;
            p = int'($urandom_range(1, 4));
            run_round($sformatf("rnd%0d", r), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 6)), p, int'($urandom_range(0, p - 1)),
                      ($urandom_range(0, 3) == 0) ? -1 : -2,
                      ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, 20)));
        end

        // Reset mid-BITE with Reel held high across reset release.
        @(negedge CLK);
        Reel = 1'b0; Start = 1'b1; Tick = 1'b0; RandIn = W'(1); Window = W'(5);
        @(negedge CLK);
        Start = 1'b0; Tick = 1'b1;
        @(posedge CLK);
        #1;
        check_outs("pre_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, W'(5));
        @(negedge CLK);
        Reel = 1'b1; RST = 1'b1; Tick = 1'b0;
        @(posedge CLK);
        #1;
        check_outs("rst_bite", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_release edge", W'(dut.u_reel_edge.Pulse), W'(0));
        @(posedge CLK);
        #1;
        check_outs("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        // Round with Reel still held: no edge, so the window must expire.
        @(negedge CLK);
        Start = 1'b1; RandIn = W'(1); Window = W'(1); Tick = 1'b0;
        @(negedge CLK);
        Start = 1'b0; Tick = 1'b1;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        check_outs("held_reel", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fish_bite_timer.md
FISH_BITE_TIMER -- requirements
Module: fish_bite_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: width of the delay and window counters and data ports.
REQ-002 SHALL have port CLK, input, 1: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port Start, input, 1: start of a round; sampled only in IDLE or DONE.
REQ-005 SHALL have port Reel, input, 1: player reel button, debounced level; only rising edges are used.
REQ-006 SHALL have port Tick, input, 1: one-cycle time-base enable (1 ms); all counting is gated by it.
REQ-007 SHALL have port RandIn, input, WIDTH: random delay in ticks, from the ranged LFSR output.
REQ-008 SHALL have port Window, input, WIDTH: bite window length in ticks.
REQ-009 SHALL have port RandRun, output, 1: one-cycle request to the ranged LFSR to advance.
REQ-010 SHALL have port Bite, output, 1: fish on the line; high throughout BITE.
REQ-011 SHALL have ports Caught, Missed and Early, each output, 1: round result flags, mutually exclusive.
REQ-012 SHALL have port Busy, output, 1: high in WAIT or BITE.
REQ-013 SHALL have port Remain, output, WIDTH: active counter value in WAIT/BITE; 0 otherwise.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, BITE and DONE; all outputs registered.
REQ-015 SHALL detect Reel rising edges as Reel=1 with the previous sampled Reel=0.
REQ-016 In IDLE or DONE with Start=1: load DelayCnt<=RandIn (0 loads as 1), clear result flags, pulse RandRun for exactly 1 cycle, enter WAIT.
REQ-017 SHALL ignore Start in WAIT and BITE.
REQ-018 In WAIT with Tick=1: DelayCnt decrements; if DelayCnt==1, load WinCnt<=Window (0 loads as 1) and enter BITE instead.
REQ-019 In WAIT, a Reel edge sets Early=1 and enters DONE; it takes priority over a same-cycle Tick.
REQ-020 In BITE, a Reel edge sets Caught=1 and enters DONE.
REQ-021 In BITE with Tick=1: WinCnt decrements; if WinCnt==1 and there is no Reel edge, set Missed=1 and enter DONE.
REQ-022 If a Reel edge and an expiring Tick occur in the same cycle, Caught SHALL win.
REQ-023 Bite SHALL rise the cycle after the terminal WAIT Tick and fall the cycle after the Reel edge or expiry.
REQ-024 Result flags SHALL hold in DONE until the next accepted Start or RST.
REQ-025 Counters SHALL never wrap below 0; Remain = DelayCnt in WAIT, WinCnt in BITE.

Reset
REQ-026 RST=1 SHALL force IDLE, clear both counters, and drive RandRun, Bite, Caught, Missed, Early, Busy and Remain to 0, overriding any state mid-round.
REQ-027 RST SHALL set the Reel history register to 1, so a button held through reset release is not treated as an edge.

Structure
REQ-028 State encodings and the default tick rate SHALL be defined as constants in the shared game package.
REQ-029 The Reel edge detector SHALL be the sub-module rise_detect (CLK, RST, In, Pulse).

Verification
REQ-030 Start with RandIn=3 and Window=2, Tick every 4 cycles, no Reel -> RandRun pulses once; Bite rises after the 3rd Tick and lasts 2 Ticks; then Missed=1.
REQ-031 RandIn=5 and a Reel edge after the 2nd Tick -> Early=1, Bite never asserts, Remain=0.
REQ-032 RandIn=2, Window=4, Reel edge one cycle after Bite rises -> Caught=1, Bite=0 the next cycle.
REQ-033 Reel edge coincident with the final window Tick -> Caught=1, Missed=0.
REQ-034 RandIn=0 and Window=0 -> each treated as 1 Tick; also Start pulsed during WAIT -> ignored, with no extra RandRun pulse.
REQ-035 RST asserted during BITE while Reel is held high across reset release -> all outputs 0, IDLE, no Reel edge registered.
